// File: rtl/fpga_ps_config_ctrl.sv
// Passive-serial configuration sequencer for the sound FPGA: nCONFIG/nSTATUS handshake,
// LSB-first byte serialisation on dclk/data0, trailing clocks and INIT_DONE tracking.
module fpga_ps_config_ctrl #(
   parameter int CFG_LOW_CYCLES = 8,
   parameter int STATUS_TIMEOUT = 50000,
   parameter int EXTRA_DCLKS    = 10,
   parameter int INIT_TIMEOUT   = 60000
) (
   input  logic       clkin,
   input  logic       coldres_n,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] byte_data,
   input  logic       byte_valid,
   output logic       byte_ready,
   output logic       config_n,
   input  logic       status_n,
   input  logic       conf_done,
   input  logic       init_done,
   output logic       dclk,
   output logic       data0,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [1:0] err_code
);

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CFG_LOW,
      ST_WAIT_ST_HI,
      ST_WAIT_BYTE,
      ST_SHIFT,
      ST_CHECK,
      ST_TRAIL,
      ST_WAIT_INIT,
      ST_DONE,
      ST_ERR
   } state_t;

   localparam logic [15:0] LOW_LAST   = 16'(CFG_LOW_CYCLES - 1);
   localparam logic [15:0] ST_LAST    = 16'(STATUS_TIMEOUT - 1);
   localparam logic [15:0] INIT_LAST  = 16'(INIT_TIMEOUT - 1);
   localparam logic [7:0]  TRAIL_LAST = 8'(EXTRA_DCLKS - 1);

   // Synchroniser reset values: nSTATUS idles high, CONF_DONE/INIT_DONE idle low.
   localparam logic [2:0]  SYNC_INIT  = 3'b001;

   logic [2:0] sync_in;
   logic [2:0] sync_bits;
   logic       status_sync;
   logic       conf_sync;
   logic       init_sync;

   assign sync_in = {init_done, conf_done, status_n};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_sync
         logic meta_reg;
         logic stable_reg;
         always_ff @(posedge clkin or negedge coldres_n) begin
            if (!coldres_n) begin
               meta_reg   <= SYNC_INIT[gi];
               stable_reg <= SYNC_INIT[gi];
            end else begin
               meta_reg   <= sync_in[gi];
               stable_reg <= meta_reg;
            end
         end
         assign sync_bits[gi] = stable_reg;
      end
   endgenerate

   assign status_sync = sync_bits[0];
   assign conf_sync   = sync_bits[1];
   assign init_sync   = sync_bits[2];

   state_t      state_reg, state_next;
   logic [15:0] cnt_reg, cnt_next;
   logic [2:0]  bit_idx_reg, bit_idx_next;
   logic        phase_reg, phase_next;
   logic [7:0]  trail_reg, trail_next;
   logic [7:0]  byte_reg, byte_next;
   logic [1:0]  err_code_reg, err_code_next;

   logic config_n_reg, config_n_next;
   logic dclk_reg, dclk_next;
   logic data0_reg, data0_next;
   logic byte_ready_reg, byte_ready_next;
   logic busy_reg, busy_next;
   logic done_reg, done_next;
   logic error_reg, error_next;

   always_ff @(posedge clkin or negedge coldres_n) begin
      if (!coldres_n) begin
         state_reg      <= ST_IDLE;
         cnt_reg        <= '0;
         bit_idx_reg    <= '0;
         phase_reg      <= 1'b0;
         trail_reg      <= '0;
         byte_reg       <= '0;
         err_code_reg   <= 2'b00;
         config_n_reg   <= 1'b1;
         dclk_reg       <= 1'b0;
         data0_reg      <= 1'b0;
         byte_ready_reg <= 1'b0;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
         error_reg      <= 1'b0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         bit_idx_reg    <= bit_idx_next;
         phase_reg      <= phase_next;
         trail_reg      <= trail_next;
         byte_reg       <= byte_next;
         err_code_reg   <= err_code_next;
         config_n_reg   <= config_n_next;
         dclk_reg       <= dclk_next;
         data0_reg      <= data0_next;
         byte_ready_reg <= byte_ready_next;
         busy_reg       <= busy_next;
         done_reg       <= done_next;
         error_reg      <= error_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      bit_idx_next  = bit_idx_reg;
      phase_next    = phase_reg;
      trail_next    = trail_reg;
      byte_next     = byte_reg;
      err_code_next = err_code_reg;

      case (state_reg)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
               state_next    = ST_CFG_LOW;
               err_code_next = 2'b00;
            end
         end
         ST_CFG_LOW: begin
            cnt_next = cnt_reg + 16'd1;
            if (cnt_reg >= LOW_LAST && !status_sync) begin
               state_next = ST_WAIT_ST_HI;
            end else if (cnt_reg >= ST_LAST) begin
               state_next    = ST_ERR;
               err_code_next = 2'b01;
            end
         end
         ST_WAIT_ST_HI: begin
            cnt_next = cnt_reg + 16'd1;
            if (status_sync) begin
               state_next = ST_WAIT_BYTE;
            end else if (cnt_reg >= ST_LAST) begin
               state_next    = ST_ERR;
               err_code_next = 2'b01;
            end
         end
         ST_WAIT_BYTE: begin
            if (byte_valid && byte_ready_reg) begin
               byte_next    = byte_data;
               bit_idx_next = 3'd0;
               phase_next   = 1'b0;
               state_next   = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            phase_next = ~phase_reg;
            if (phase_reg) begin
               if (bit_idx_reg == 3'd7) begin
                  state_next = ST_CHECK;
               end else begin
                  bit_idx_next = bit_idx_reg + 3'd1;
               end
            end
         end
         ST_CHECK: begin
            // A CRC failure reported on nSTATUS outranks CONF_DONE.
            if (!status_sync) begin
               state_next    = ST_ERR;
               err_code_next = 2'b10;
            end else if (conf_sync) begin
               state_next = ST_TRAIL;
               trail_next = '0;
               phase_next = 1'b0;
            end else begin
               state_next = ST_WAIT_BYTE;
            end
         end
         ST_TRAIL: begin
            phase_next = ~phase_reg;
            if (phase_reg) begin
               if (trail_reg == TRAIL_LAST) begin
                  state_next = ST_WAIT_INIT;
               end else begin
                  trail_next = trail_reg + 8'd1;
               end
            end
         end
         ST_WAIT_INIT: begin
            cnt_next = cnt_reg + 16'd1;
            if (init_sync) begin
               state_next = ST_DONE;
            end else if (cnt_reg >= INIT_LAST) begin
               state_next    = ST_ERR;
               err_code_next = 2'b11;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      if (abort) begin
         state_next    = ST_IDLE;
         err_code_next = 2'b00;
      end

      // Every timed state starts counting from zero.
      if (state_next != state_reg) begin
         cnt_next = '0;
      end
   end

   // Outputs are decoded from the next state and registered, so dclk cannot glitch.
   always_comb begin
      config_n_next   = (state_next != ST_CFG_LOW);
      dclk_next       = 1'b0;
      data0_next      = 1'b0;
      byte_ready_next = (state_next == ST_WAIT_BYTE);
      busy_next       = !(state_next == ST_IDLE || state_next == ST_DONE ||
                          state_next == ST_ERR);
      done_next       = (state_next == ST_DONE);
      error_next      = (state_next == ST_ERR);
      case (state_next)
         ST_SHIFT: begin
            dclk_next  = phase_next;
            data0_next = byte_next[bit_idx_next];
         end
         ST_TRAIL: begin
            dclk_next  = phase_next;
            data0_next = 1'b1;
         end
         default: begin
            dclk_next  = 1'b0;
            data0_next = 1'b0;
         end
      endcase
   end

   assign config_n   = config_n_reg;
   assign dclk       = dclk_reg;
   assign data0      = data0_reg;
   assign byte_ready = byte_ready_reg;
   assign busy       = busy_reg;
   assign done       = done_reg;
   assign error      = error_reg;
   assign err_code   = err_code_reg;

endmodule

// File: tb/tb_fpga_ps_config_ctrl.sv
// Bench for fpga_ps_config_ctrl: FPGA pin model, scenario table, abort/stall/reset sequences.
`timescale 1ns/1ps
module tb_fpga_ps_config_ctrl;
   localparam int CFG_LOW = 8;
   localparam int ST_TO   = 100;
   localparam int EXTRA   = 10;
   localparam int INIT_TO = 200;

   logic       clkin = 1'b0;
   logic       coldres_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] byte_data = 8'h00;
   logic       byte_valid = 1'b0;
   logic       status_n = 1'b1;
   logic       conf_done = 1'b0;
   logic       init_done = 1'b0;
   logic       byte_ready, config_n, dclk, data0, busy, done, error;
   logic [1:0] err_code;

   always #5 clkin = ~clkin;

   fpga_ps_config_ctrl #(
      .CFG_LOW_CYCLES(CFG_LOW),
      .STATUS_TIMEOUT(ST_TO),
      .EXTRA_DCLKS(EXTRA),
      .INIT_TIMEOUT(INIT_TO)
   ) dut (
      .clkin(clkin), .coldres_n(coldres_n), .start(start), .abort(abort),
      .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
      .config_n(config_n), .status_n(status_n), .conf_done(conf_done),
      .init_done(init_done), .dclk(dclk), .data0(data0), .busy(busy),
      .done(done), .error(error), .err_code(err_code)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   // FPGA pin model, evaluated 2ns after each rising edge.
   int   m_conf_at = -1;
   int   m_crc_at = -1;
   int   m_init_at = -1;
   bit   m_stuck = 1'b0;
   int   rise_cnt = 0;
   int   low_len = 0;
   int   last_low_len = 0;
   int   hi_timer = -1;
   int   init_timer = -1;
   logic cfg_prev = 1'b1;
   logic dclk_prev = 1'b0;
   logic cap [64];

   always @(posedge clkin) begin
      #2;
      if (!config_n) begin
         if (cfg_prev) begin
            rise_cnt = 0; conf_done = 0; init_done = 0; low_len = 0; init_timer = -1;
            if (m_stuck) status_n = 1'b1;
         end
         low_len++;
         if (!m_stuck && low_len == 3) status_n = 1'b0;
      end else begin
         if (!cfg_prev) begin
            last_low_len = low_len;
            hi_timer = 0;
         end
         if (hi_timer >= 0) begin
            hi_timer++;
            if (hi_timer == 20) begin
               if (!m_stuck) status_n = 1'b1;
               hi_timer = -1;
            end
         end
      end
      if (dclk && !dclk_prev) begin
         if (rise_cnt < 64) cap[rise_cnt] = data0;
         rise_cnt++;
         if (rise_cnt == m_conf_at) conf_done = 1'b1;
         if (rise_cnt == m_crc_at) status_n = 1'b0;
         if (rise_cnt == m_init_at) init_timer = 0;
      end
      if (init_timer >= 0) begin
         init_timer++;
         if (init_timer == 5) begin
            init_done = 1'b1;
            init_timer = -1;
         end
      end
      cfg_prev = config_n;
      dclk_prev = dclk;
   end

   // Byte source
   logic [31:0] feed_bytes = '0;
   int nfeed = 0;
   int fidx = 0;

   task automatic drive_feed();
      byte_valid = (fidx < nfeed);
      if (fidx < 4) byte_data = feed_bytes[fidx*8 +: 8];
      else          byte_data = 8'h00;
   endtask

   task automatic set_feed(input int n, input logic [31:0] b);
      nfeed = n; feed_bytes = b; fidx = 0;
      drive_feed();
   endtask

   // One clock: inputs change 1ns after the rising edge, caller resumes at the falling edge.
   task automatic tick();
      bit hs;
      hs = byte_ready && byte_valid;
      @(posedge clkin);
      #1;
      if (hs) fidx++;
      start = 1'b0;
      abort = 1'b0;
      drive_feed();
      @(negedge clkin);
   endtask

   task automatic wait_idle(output int elapsed, output bit ok);
      elapsed = 0;
      ok = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         tick();
         elapsed++;
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic set_model(input bit stuck, input int conf_at, input int crc_at, input int init_at);
      m_stuck = stuck; m_conf_at = conf_at; m_crc_at = crc_at; m_init_at = init_at;
   endtask

   typedef struct {
      logic [95:0] name;
      int          nfeed;
      logic [31:0] bytes;
      bit          stuck;
      int          conf_at;
      int          crc_at;
      int          init_at;
      bit          exp_done;
      bit          exp_error;
      logic [1:0]  exp_code;
      int          exp_acc;
      int          exp_rises;
      int          exp_cycles;
   } vec_t;

   vec_t vecs [5];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int  el;
      bit  ok;
      int  cnt_a, cnt_b, cnt_c;
      logic [7:0] got;

      vecs[0] = '{"nominal",    2, 32'h00003CA5, 1'b0, 15, -1, 26, 1'b1, 1'b0, 2'b00, 2, 26, 0};
      vecs[1] = '{"st_timeout", 2, 32'h00003CA5, 1'b1, -1, -1, -1, 1'b0, 1'b1, 2'b01, 0, 0, 100};
      vecs[2] = '{"crc_err",    4, 32'h775A2211, 1'b0, -1, 18, -1, 1'b0, 1'b1, 2'b10, 3, 24, 0};
      vecs[3] = '{"init_to",    1, 32'h000000C3, 1'b0,  7, -1, -1, 1'b0, 1'b1, 2'b11, 1, 18, 0};
      vecs[4] = '{"one_byte",   1, 32'h00000081, 1'b0,  7, -1, 18, 1'b1, 1'b0, 2'b00, 1, 18, 0};

      // Reset state
      repeat (3) @(negedge clkin);
      chk("rst_config_n", int'(config_n), 1);
      chk("rst_dclk", int'(dclk), 0);
      chk("rst_data0", int'(data0), 0);
      chk("rst_byte_ready", int'(byte_ready), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_error", int'(error), 0);
      chk("rst_err_code", int'(err_code), 0);
      coldres_n = 1'b1;
      repeat (3) tick();

      // Scenario table
      for (int r = 0; r < 5; r++) begin
         set_model(vecs[r].stuck, vecs[r].conf_at, vecs[r].crc_at, vecs[r].init_at);
         set_feed(vecs[r].nfeed, vecs[r].bytes);
         start = 1'b1;
         tick();
         wait_idle(el, ok);
         chk("idle_reached", int'(ok), 1);
         repeat (20) tick();
         chk("done", int'(done), int'(vecs[r].exp_done));
         chk("error", int'(error), int'(vecs[r].exp_error));
         chk("err_code", int'(err_code), int'(vecs[r].exp_code));
         chk("busy_end", int'(busy), 0);
         chk("config_n_end", int'(config_n), 1);
         chk("dclk_end", int'(dclk), 0);
         chk("bytes_accepted", fidx, vecs[r].exp_acc);
         chk("dclk_rises", rise_cnt, vecs[r].exp_rises);
         chk("config_n_low_min", int'(last_low_len >= CFG_LOW), 1);
         for (int j = 0; j < vecs[r].exp_acc && j < 4; j++) begin
            for (int k = 0; k < 8; k++) got[k] = cap[8*j + k];
            chk("serial_byte", int'(got), int'(vecs[r].bytes[8*j +: 8]));
         end
         if (vecs[r].exp_rises > 8*vecs[r].exp_acc) begin
            cnt_a = 0;
            for (int i = 8*vecs[r].exp_acc; i < rise_cnt && i < 64; i++) cnt_a += int'(cap[i]);
            chk("trail_data_ones", cnt_a, EXTRA);
         end
         if (vecs[r].exp_cycles > 0)
            chk("timeout_cycles", int'(el >= vecs[r].exp_cycles - 3 && el <= vecs[r].exp_cycles + 3), 1);
         $display("row %0s: done=%0d error=%0d code=%0d accepted=%0d rises=%0d cycles=%0d",
                  vecs[r].name, done, error, err_code, fidx, rise_cnt, el);
      end

      // Abort during phase B of bit 4, then a full configuration.
      set_model(1'b0, 15, -1, 26);
      set_feed(2, 32'h00003CA5);
      start = 1'b1;
      tick();
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if (dclk && rise_cnt == 5) begin ok = 1'b1; break; end
         tick();
      end
      chk("abort_reach_bit4", int'(ok), 1);
      abort = 1'b1;
      start = 1'b1;
      tick();
      chk("abort_dclk", int'(dclk), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_config_n", int'(config_n), 1);
      chk("abort_err_code", int'(err_code), 0);
      repeat (3) tick();
      chk("abort_beats_start", int'(busy), 0);
      chk("abort_byte_kept", fidx, 1);
      $display("abort: dclk=%0d busy=%0d config_n=%0d", dclk, busy, config_n);
      set_feed(2, 32'h00003CA5);
      start = 1'b1;
      tick();
      wait_idle(el, ok);
      chk("after_abort_done", int'(done), 1);
      for (int k = 0; k < 8; k++) got[k] = cap[k];
      chk("after_abort_byte0", int'(got), 32'hA5);
      $display("restart after abort: done=%0d error=%0d", done, error);

      // Stall in WAIT_BYTE with a start pulse while busy.
      set_feed(0, 32'h0);
      start = 1'b1;
      tick();
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if (byte_ready) begin ok = 1'b1; break; end
         tick();
      end
      chk("stall_reach_wait_byte", int'(ok), 1);
      cnt_a = 0; cnt_b = 0; cnt_c = 0;
      for (int i = 0; i < 500; i++) begin
         if (i == 250) start = 1'b1;
         tick();
         cnt_a += int'(dclk);
         cnt_b += int'(!config_n);
         cnt_c += int'(!busy || error);
      end
      chk("stall_dclk_high", cnt_a, 0);
      chk("stall_config_low", cnt_b, 0);
      chk("stall_not_busy", cnt_c, 0);
      chk("stall_byte_ready", int'(byte_ready), 1);
      set_feed(2, 32'h00003CA5);
      wait_idle(el, ok);
      chk("stall_done", int'(done), 1);
      start = 1'b1;
      tick();
      chk("restart_done_clr", int'(done), 0);
      chk("restart_config_n", int'(config_n), 0);
      chk("restart_busy", int'(busy), 1);
      set_feed(2, 32'h00003CA5);
      wait_idle(el, ok);
      chk("restart_done", int'(done), 1);
      $display("stall/restart: done=%0d error=%0d", done, error);

      // Asynchronous reset mid-byte.
      set_feed(2, 32'h00003CA5);
      start = 1'b1;
      tick();
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if (rise_cnt >= 3 && dclk) begin ok = 1'b1; break; end
         tick();
      end
      chk("reset_reach_shift", int'(ok), 1);
      coldres_n = 1'b0;
      #1;
      chk("async_rst_dclk", int'(dclk), 0);
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_config_n", int'(config_n), 1);
      chk("async_rst_done", int'(done), 0);
      @(negedge clkin);
      coldres_n = 1'b1;
      set_feed(0, 32'h0);
      repeat (3) tick();
      chk("post_rst_idle", int'(busy), 0);
      $display("mid-op reset: busy=%0d config_n=%0d", busy, config_n);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
